// File: rtl/lbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : lbus_arbiter
// Description : Local memory bus arbiter for CPU cycle control, DMA and a
//               self-timed DRAM refresh. Owns the refresh interval timer and
//               produces the registered one-hot grants plus WAIT1/WAIT2.
//               Optional macro ARB_FAIR_EN bounds DMA bursts while CPU waits.
// Revision    : 1.0 - initial release
// ============================================================================
module lbus_arbiter #(
    parameter int REFRESH_PERIOD = 390,
    parameter int REFRESH_LEN    = 4,
    parameter int TURNAROUND     = 1,
    parameter int DMA_BURST_MAX  = 4
) (
    input  logic CK,
    input  logic RST,
    input  logic CREQ,
    input  logic DREQ,
    output logic CGNT_n,
    output logic DGNT_n,
    output logic RGNT_n,
    output logic WAIT1,
    output logic WAIT2,
    output logic RFOVR
);

    localparam logic [11:0] c_timer_reload = 12'(REFRESH_PERIOD - 1);
    localparam logic [3:0]  c_rlen_load    = 4'(REFRESH_LEN - 1);
    localparam logic [1:0]  c_turn_load    = 2'(TURNAROUND - 1);

    // Reject out-of-range configurations at elaboration time.
    if (REFRESH_PERIOD < 8 || REFRESH_PERIOD > 4095 || REFRESH_LEN < 1 ||
        REFRESH_LEN > 15 || TURNAROUND < 1 || TURNAROUND > 3 ||
        DMA_BURST_MAX < 1 || DMA_BURST_MAX > 7) begin : g_param_check
        $error("lbus_arbiter: parameter out of range");
    end

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CPU  = 3'd1,
        ST_DMA  = 3'd2,
        ST_REFR = 3'd3,
        ST_TURN = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] timer_q, timer_d;
    logic        rfpend_q, rfpend_d;
    logic        rfovr_q, rfovr_d;
    logic [1:0]  turn_cnt_q, turn_cnt_d;
    logic [3:0]  rlen_cnt_q, rlen_cnt_d;
    logic        enter_refr;
    logic        timer_expire;
    logic        fair_cpu_pref;

`ifdef ARB_FAIR_EN
    localparam logic [2:0] c_burst_max = 3'(DMA_BURST_MAX);

    logic [2:0] burst_q, burst_d;

    // Once the burst limit is reached a waiting CPU wins the next arbitration.
    assign fair_cpu_pref = (burst_q >= c_burst_max);

    // Count DMA grants issued while the CPU waits; clear on CPU grant or idle CPU.
    always_comb begin
        burst_d = burst_q;
        if (state_q == ST_IDLE) begin
            if (!CREQ) begin
                burst_d = 3'd0;
            end else if (state_d == ST_CPU) begin
                burst_d = 3'd0;
            end else if (state_d == ST_DMA && burst_q != 3'd7) begin
                burst_d = burst_q + 3'd1;
            end
        end
    end

    // Burst counter register.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            burst_q <= 3'd0;
        end else begin
            burst_q <= burst_d;
        end
    end
`else
    assign fair_cpu_pref = 1'b0;
`endif

    // Free-running refresh interval timer, pending flag and sticky overrun.
    always_comb begin
        timer_expire = (timer_q == 12'd0);
        timer_d      = timer_expire ? c_timer_reload : (timer_q - 12'd1);
        // A new expiry wins over the clear caused by entering REFR.
        rfpend_d     = timer_expire | (rfpend_q & ~enter_refr);
        rfovr_d      = rfovr_q | (timer_expire & rfpend_q);
    end

    // Arbitration next-state logic and per-state counters.
    always_comb begin
        state_d    = state_q;
        turn_cnt_d = turn_cnt_q;
        rlen_cnt_d = rlen_cnt_q;
        enter_refr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rfpend_q) begin
                    state_d    = ST_REFR;
                    rlen_cnt_d = c_rlen_load;
                    enter_refr = 1'b1;
                end else if (DREQ && !(fair_cpu_pref && CREQ)) begin
                    state_d = ST_DMA;
                end else if (CREQ) begin
                    state_d = ST_CPU;
                end
            end
            ST_CPU: begin
                if (!CREQ) begin
                    state_d    = ST_TURN;
                    turn_cnt_d = c_turn_load;
                end
            end
            ST_DMA: begin
                if (!DREQ) begin
                    state_d    = ST_TURN;
                    turn_cnt_d = c_turn_load;
                end
            end
            ST_REFR: begin
                if (rlen_cnt_q == 4'd0) begin
                    state_d    = ST_TURN;
                    turn_cnt_d = c_turn_load;
                end else begin
                    rlen_cnt_d = rlen_cnt_q - 4'd1;
                end
            end
            ST_TURN: begin
                if (turn_cnt_q == 2'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    turn_cnt_d = turn_cnt_q - 2'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and timer registers; reset releases all grants asynchronously.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            timer_q    <= c_timer_reload;
            rfpend_q   <= 1'b0;
            rfovr_q    <= 1'b0;
            turn_cnt_q <= 2'd0;
            rlen_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            rfpend_q   <= rfpend_d;
            rfovr_q    <= rfovr_d;
            turn_cnt_q <= turn_cnt_d;
            rlen_cnt_q <= rlen_cnt_d;
        end
    end

    assign CGNT_n = ~(state_q == ST_CPU);
    assign DGNT_n = ~(state_q == ST_DMA);
    assign RGNT_n = ~(state_q == ST_REFR);
    assign WAIT2  = (state_q == ST_TURN);
    assign WAIT1  = CREQ & (state_q != ST_CPU);
    assign RFOVR  = rfovr_q;

endmodule
`default_nettype wire

// File: tb/tb_lbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_lbus_arbiter
// Description : Directed self-checking bench for lbus_arbiter. One instance
//               uses the default refresh period for CPU/DMA scenarios, a second
//               uses a 16-cycle period for refresh and overrun scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lbus_arbiter;

    logic CK;
    logic RST;
    logic creq, dreq;
    logic cgnt_n, dgnt_n, rgnt_n, wait1, wait2, rfovr;
    logic creq_r, dreq_r;
    logic cgnt_r, dgnt_r, rgnt_r, wait1_r, wait2_r, rfovr_r;

    int total;
    int passed;

    lbus_arbiter #(
        .REFRESH_PERIOD(390), .REFRESH_LEN(4), .TURNAROUND(1), .DMA_BURST_MAX(4)
    ) u_dut (
        .CK(CK), .RST(RST), .CREQ(creq), .DREQ(dreq),
        .CGNT_n(cgnt_n), .DGNT_n(dgnt_n), .RGNT_n(rgnt_n),
        .WAIT1(wait1), .WAIT2(wait2), .RFOVR(rfovr)
    );

    lbus_arbiter #(
        .REFRESH_PERIOD(16), .REFRESH_LEN(4), .TURNAROUND(1), .DMA_BURST_MAX(4)
    ) u_ref (
        .CK(CK), .RST(RST), .CREQ(creq_r), .DREQ(dreq_r),
        .CGNT_n(cgnt_r), .DGNT_n(dgnt_r), .RGNT_n(rgnt_r),
        .WAIT1(wait1_r), .WAIT2(wait2_r), .RFOVR(rfovr_r)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    // Reset is released 1 time unit after an edge; the next edge is edge 1.
    task automatic do_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        creq = 1'b0; dreq = 1'b0; creq_r = 1'b0; dreq_r = 1'b0;
        tick();
        total++; if (cgnt_n !== 1'b1) $display("FAIL rst_cgnt: got %b want 1", cgnt_n); else passed++;
        total++; if (dgnt_n !== 1'b1) $display("FAIL rst_dgnt: got %b want 1", dgnt_n); else passed++;
        total++; if (rgnt_n !== 1'b1) $display("FAIL rst_rgnt: got %b want 1", rgnt_n); else passed++;
        total++; if (wait2 !== 1'b0) $display("FAIL rst_wait2: got %b want 0", wait2); else passed++;
        total++; if (rfovr !== 1'b0) $display("FAIL rst_rfovr: got %b want 0", rfovr); else passed++;
        total++; if (wait1 !== 1'b0) $display("FAIL rst_wait1_lo: got %b want 0", wait1); else passed++;
        creq = 1'b1;
        #1;
        total++; if (wait1 !== 1'b1) $display("FAIL rst_wait1_hi: got %b want 1", wait1); else passed++;
        creq = 1'b0;
        RST = 1'b0;
    endtask

    task automatic test_cpu_grant();
        do_reset();
        tick();
        tick();
        creq = 1'b1;
        #1;
        total++; if (cgnt_n !== 1'b1) $display("FAIL cpu_pre_grant: got %b want 1", cgnt_n); else passed++;
        total++; if (wait1 !== 1'b1) $display("FAIL cpu_wait1_req: got %b want 1", wait1); else passed++;
        tick();
        total++; if (cgnt_n !== 1'b0) $display("FAIL cpu_grant: got %b want 0", cgnt_n); else passed++;
        total++; if (wait1 !== 1'b0) $display("FAIL cpu_wait1_gnt: got %b want 0", wait1); else passed++;
        tick();
        tick();
        tick();
        total++; if (cgnt_n !== 1'b0) $display("FAIL cpu_hold: got %b want 0", cgnt_n); else passed++;
        creq = 1'b0;
        tick();
        total++; if (cgnt_n !== 1'b1) $display("FAIL cpu_release: got %b want 1", cgnt_n); else passed++;
        total++; if (wait2 !== 1'b1) $display("FAIL cpu_turn_wait2: got %b want 1", wait2); else passed++;
        tick();
        total++; if (wait2 !== 1'b0) $display("FAIL cpu_idle_wait2: got %b want 0", wait2); else passed++;
    endtask

    task automatic test_dma_priority();
        do_reset();
        creq = 1'b1;
        dreq = 1'b1;
        tick();
        total++; if (dgnt_n !== 1'b0) $display("FAIL dma_win: got %b want 0", dgnt_n); else passed++;
        total++; if (cgnt_n !== 1'b1) $display("FAIL dma_cpu_lose: got %b want 1", cgnt_n); else passed++;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (wait1 !== 1'b1) $display("FAIL dma_wait1 cyc %0d: got %b want 1", i, wait1); else passed++;
        end
        dreq = 1'b0;
        tick();
        total++; if (dgnt_n !== 1'b1) $display("FAIL dma_release: got %b want 1", dgnt_n); else passed++;
        total++; if (wait2 !== 1'b1) $display("FAIL dma_turn: got %b want 1", wait2); else passed++;
        total++; if (wait1 !== 1'b1) $display("FAIL dma_turn_wait1: got %b want 1", wait1); else passed++;
        tick();
        total++; if (cgnt_n !== 1'b1) $display("FAIL dma_idle_cgnt: got %b want 1", cgnt_n); else passed++;
        tick();
        total++; if (cgnt_n !== 1'b0) $display("FAIL dma_then_cpu: got %b want 0", cgnt_n); else passed++;
        total++; if (wait1 !== 1'b0) $display("FAIL dma_then_cpu_wait1: got %b want 0", wait1); else passed++;
        creq = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        creq = 1'b1;
        tick();
        dreq = 1'b1;
        tick();
        total++; if (cgnt_n !== 1'b0) $display("FAIL b2b_no_preempt_c: got %b want 0", cgnt_n); else passed++;
        total++; if (dgnt_n !== 1'b1) $display("FAIL b2b_no_preempt_d: got %b want 1", dgnt_n); else passed++;
        creq = 1'b0;
        tick();
        total++; if ({cgnt_n, dgnt_n} !== 2'b11) $display("FAIL b2b_turn: got %b want 11", {cgnt_n, dgnt_n}); else passed++;
        tick();
        tick();
        total++; if (dgnt_n !== 1'b0) $display("FAIL b2b_dma: got %b want 0", dgnt_n); else passed++;
        dreq = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_refresh();
        logic exp_act;
        creq_r = 1'b0;
        dreq_r = 1'b0;
        do_reset();
        for (int n = 1; n <= 40; n++) begin
            tick();
            exp_act = (n >= 17 && n <= 20) || (n >= 33 && n <= 36);
            total++; if (rgnt_r !== ~exp_act) $display("FAIL refresh_rgnt edge %0d: got %b want %b", n, rgnt_r, ~exp_act); else passed++;
            if (n == 21) begin
                total++; if (wait2_r !== 1'b1) $display("FAIL refresh_turn: got %b want 1", wait2_r); else passed++;
            end
        end
        total++; if (rfovr_r !== 1'b0) $display("FAIL refresh_no_ovr: got %b want 0", rfovr_r); else passed++;
    endtask

    task automatic test_overrun();
        dreq_r = 1'b1;
        do_reset();
        for (int n = 1; n <= 47; n++) begin
            tick();
            case (n)
                1:  begin total++; if (dgnt_r !== 1'b0) $display("FAIL ovr_dma: got %b want 0", dgnt_r); else passed++; end
                31: begin total++; if (rfovr_r !== 1'b0) $display("FAIL ovr_early: got %b want 0", rfovr_r); else passed++; end
                32: begin total++; if (rfovr_r !== 1'b1) $display("FAIL ovr_set: got %b want 1", rfovr_r); else passed++; end
                40: begin
                    total++; if (rgnt_r !== 1'b1) $display("FAIL ovr_no_preempt: got %b want 1", rgnt_r); else passed++;
                    dreq_r = 1'b0;
                end
                41: begin total++; if (wait2_r !== 1'b1) $display("FAIL ovr_turn: got %b want 1", wait2_r); else passed++; end
                42: begin total++; if (rgnt_r !== 1'b1) $display("FAIL ovr_idle: got %b want 1", rgnt_r); else passed++; end
                43: begin total++; if (rgnt_r !== 1'b0) $display("FAIL ovr_refr: got %b want 0", rgnt_r); else passed++; end
                46: begin total++; if (rgnt_r !== 1'b0) $display("FAIL ovr_refr_end: got %b want 0", rgnt_r); else passed++; end
                47: begin total++; if (rgnt_r !== 1'b1) $display("FAIL ovr_refr_len: got %b want 1", rgnt_r); else passed++; end
                default: ;
            endcase
        end
        total++; if (rfovr_r !== 1'b1) $display("FAIL ovr_sticky: got %b want 1", rfovr_r); else passed++;
        do_reset();
        total++; if (rfovr_r !== 1'b0) $display("FAIL ovr_reset_clear: got %b want 0", rfovr_r); else passed++;
    endtask

    task automatic test_fairness();
        int dma_cnt;
        int dma_before;
        int cyc;
        int exp_before;
        logic cpu_seen;
`ifdef ARB_FAIR_EN
        exp_before = 4;
`else
        exp_before = 5;
`endif
        dma_cnt = 0;
        dma_before = 0;
        cyc = 0;
        cpu_seen = 1'b0;
        do_reset();
        creq = 1'b1;
        dreq = 1'b1;
        while (!(dma_cnt == 5 && cpu_seen) && cyc < 300) begin
            tick();
            cyc++;
            if (!dgnt_n) begin
                dma_cnt++;
                if (!cpu_seen) dma_before++;
                dreq = 1'b0;
                tick();
                cyc++;
                if (dma_cnt < 5) dreq = 1'b1;
            end else if (!cgnt_n) begin
                cpu_seen = 1'b1;
                creq = 1'b0;
                tick();
                cyc++;
            end
        end
        total++; if (cyc >= 300) $display("FAIL fair_timeout: got %0d cycles want <300", cyc); else passed++;
        total++; if (dma_before !== exp_before) $display("FAIL fair_dma_before_cpu: got %0d want %0d", dma_before, exp_before); else passed++;
        total++; if (dma_cnt !== 5) $display("FAIL fair_dma_total: got %0d want 5", dma_cnt); else passed++;
        creq = 1'b0;
        dreq = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        creq = 1'b1;
        tick();
        total++; if (cgnt_n !== 1'b0) $display("FAIL arst_pre: got %b want 0", cgnt_n); else passed++;
        RST = 1'b1;
        #1;
        total++; if (cgnt_n !== 1'b1) $display("FAIL arst_release: got %b want 1", cgnt_n); else passed++;
        total++; if (wait1 !== 1'b1) $display("FAIL arst_wait1: got %b want 1", wait1); else passed++;
        tick();
        RST = 1'b0;
        tick();
        total++; if (cgnt_n !== 1'b0) $display("FAIL arst_regrant: got %b want 0", cgnt_n); else passed++;
        creq = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        total = 0;
        passed = 0;
        creq = 1'b0; dreq = 1'b0; creq_r = 1'b0; dreq_r = 1'b0;
        RST = 1'b1;
        test_reset();
        test_cpu_grant();
        test_dma_priority();
        test_back_to_back();
        test_refresh();
        test_overrun();
        test_fairness();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
